// File: rtl/miriscv_pkg.sv
// miriscv_pkg: types and constants shared by the fetch path.
package miriscv_pkg;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;
  // Width of the stale-response counter. It must cover the memory's deepest
  // in-flight window across back-to-back redirects.
  localparam int DISC_W  = 8;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic            misalign;
  } fetch_entry_t;
endpackage

// File: rtl/miriscv_fetch_fifo.sv
// miriscv_fetch_fifo: synchronous FIFO of fetch entries. It has a one-cycle flush and
// a head read straight from the storage registers.
module miriscv_fetch_fifo
  import miriscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
)(
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  // Flush overrides both push and pop. Popping an empty queue is ignored.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage. It holds data only, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/miriscv_fetch_buffer.sv
// miriscv_fetch_buffer: sequential instruction fetch with a prefetch FIFO and
// redirect handling. Responses that belong to a pre-redirect stream are counted
// and dropped.
// Optional feature: MIRISCV_FETCH_MISALIGN_EN. With it defined, a misaligned
// redirect target produces a single fault entry instead of memory requests.
module miriscv_fetch_buffer
  import miriscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
)(
  input  logic            clk_i,
  input  logic            arstn_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            fetch_misalign_o
);
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic              run;
  logic [XLEN-1:0]   addr, head_pc, target;
  logic [CW-1:0]     outstanding, count;
  logic [DISC_W-1:0] discard;
  logic              grant, keep, drop, pop, push, mis_push, lock;
  fetch_entry_t      head, push_entry;

  // Requests stay off for the first cycle after reset. Stored plus in-flight
  // words are capped at DEPTH, so a response always finds a free slot.
  assign instr_req_o  = run && !redirect_i && !lock &&
                        (({1'b0, count} + {1'b0, outstanding}) < LIMIT);
  assign grant        = instr_req_o && instr_gnt_i;
  assign keep         = instr_rvalid_i && (discard == '0);
  assign drop         = instr_rvalid_i && (discard != '0);
  assign pop          = fetch_valid_o && fetch_ready_i && !redirect_i;
  assign instr_addr_o = addr;
  assign fetch_valid_o = (count != '0);
  assign fetch_pc_o    = head_pc;
  assign fetch_instr_o = XLEN'(head.instr);

`ifdef MIRISCV_FETCH_MISALIGN_EN
  logic lock_q, pend;

  assign target           = redirect_pc_i;
  assign lock             = lock_q;
  assign mis_push         = pend && (discard == '0) && !redirect_i;
  assign fetch_misalign_o = fetch_valid_o && head.misalign;

  // A misaligned target blocks fetch until the next redirect. It queues one
  // fault entry once the stale responses have drained.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      lock_q <= 1'b0;
      pend   <= 1'b0;
    end else if (redirect_i) begin
      lock_q <= |target[1:0];
      pend   <= |target[1:0];
    end else if (mis_push) begin
      pend   <= 1'b0;
    end
  end
`else
  logic [1:0] unused_pc_lo;
  logic       unused_misalign;

  assign unused_pc_lo     = redirect_pc_i[1:0];
  assign unused_misalign  = head.misalign;
  assign target           = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign lock             = 1'b0;
  assign mis_push         = 1'b0;
  assign fetch_misalign_o = 1'b0;
`endif

  // Choose the FIFO write: a memory word, or the misaligned-target fault entry.
  always_comb begin
    push_entry = '{instr: instr_rdata_i[ILEN-1:0], misalign: 1'b0};
    push       = keep;
    if (mis_push) begin
      push_entry = '{instr: '0, misalign: 1'b1};
      push       = 1'b1;
    end
  end

  // Request address and head PC. A redirect reloads both with the target.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      run     <= 1'b0;
      addr    <= RESET_PC;
      head_pc <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (redirect_i) begin
        addr    <= target;
        head_pc <= target;
      end else begin
        if (grant) addr    <= addr + XLEN'(PC_STEP);
        if (pop)   head_pc <= head_pc + XLEN'(PC_STEP);
      end
    end
  end

  // Live and stale in-flight counters. On a redirect, every live word becomes stale.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      outstanding <= '0;
      discard     <= discard + DISC_W'(outstanding) - DISC_W'(instr_rvalid_i);
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(keep);
      discard     <= discard - DISC_W'(drop);
    end
  end

  miriscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush   (redirect_i),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  // A response is legal only while a request is still in flight.
  rvalid_expected: assert property (@(posedge clk_i) disable iff (!arstn_i)
    !(instr_rvalid_i && (outstanding == '0) && (discard == '0)));
endmodule

// File: tb/tb_miriscv_fetch_buffer.sv
// tb_miriscv_fetch_buffer: random and directed stimulus. Outputs are checked every
// cycle against a queue-based model of the fetch stream.
module tb_miriscv_fetch_buffer;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk_i = 1'b0, arstn_i = 1'b1;
  logic              instr_req_o, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [XLEN-1:0]   instr_addr_o, instr_rdata_i = '0;
  logic              redirect_i = 1'b0, fetch_valid_o, fetch_ready_i = 1'b0, fetch_misalign_o;
  logic [XLEN-1:0]   redirect_pc_i = '0, fetch_instr_o, fetch_pc_o;

  always #5 clk_i = ~clk_i;

  miriscv_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o), .fetch_misalign_o(fetch_misalign_o)
  );

  int checks = 0, failures = 0, cyc = 0;
  int p_gnt = 100, p_rv = 100, p_ready = 100, p_redir = 0;
  bit nop_mem = 1'b0, f_redir = 1'b0;
  logic [31:0] f_pc = '0;

  typedef struct { logic [31:0] addr; int due; }                mreq_t;
  typedef struct { bit live; logic [31:0] pc; }                 fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit mis; } ent_t;
  mreq_t mq[$];    // memory: granted, not yet returned
  fl_t   infl[$];  // model: in-flight words, live or stale
  ent_t  fq[$];    // model: entries visible to decode
  logic [31:0] m_addr = RESET_PC, m_mpc = '0;
  bit m_run = 1'b0, m_lock = 1'b0, m_pend = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return nop_mem ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    fq.delete(); infl.delete(); mq.delete();
    m_addr = RESET_PC; m_run = 1'b1; m_lock = 1'b0; m_pend = 1'b0;
  endtask

  // Assert reset mid-cycle, check that the outputs clear asynchronously, then release on a negedge.
  task automatic do_reset();
    #2 arstn_i = 1'b0;
    redirect_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; fetch_ready_i = 1'b0;
    #1;
    chk("rst_req",   instr_req_o,      32'd0);
    chk("rst_valid", fetch_valid_o,    32'd0);
    chk("rst_mis",   fetch_misalign_o, 32'd0);
    chk("rst_addr",  instr_addr_o,     RESET_PC);
    chk("rst_pc",    fetch_pc_o,       RESET_PC);
    model_reset();
    @(negedge clk_i); @(negedge clk_i);
    arstn_i = 1'b1;
  endtask

  // One clock: drive, compare with the model at the negedge, then advance the memory and the model.
  task automatic step();
    int live;
    bit req_e, pop_e, mis_e;
    logic [31:0] tgt;
    fl_t f;
    @(posedge clk_i); #1;
    instr_gnt_i    = ($urandom % 100) < p_gnt;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc && ($urandom % 100) < p_rv) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = word(mq[0].addr);
    end
    fetch_ready_i = ($urandom % 100) < p_ready;
    if (f_redir) begin
      redirect_i = 1'b1; redirect_pc_i = f_pc; f_redir = 1'b0;
    end else begin
      redirect_i    = ($urandom % 100) < p_redir;
      redirect_pc_i = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) redirect_pc_i[1:0] = 2'b00;
    end
    @(negedge clk_i);
    live = 0;
    foreach (infl[i]) if (infl[i].live) live++;
    req_e = m_run && !redirect_i && !m_lock && (fq.size() + live < DEPTH);
    chk("m_req",   instr_req_o,   32'(req_e));
    chk("m_addr",  instr_addr_o,  m_addr);
    chk("m_valid", fetch_valid_o, 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk("m_pc",    fetch_pc_o,       fq[0].pc);
      chk("m_instr", fetch_instr_o,    fq[0].instr);
      chk("m_mis",   fetch_misalign_o, 32'(fq[0].mis));
    end
    // memory bookkeeping (one-cycle minimum latency, in order)
    if (instr_rvalid_i) void'(mq.pop_front());
    if (instr_req_o && instr_gnt_i) mq.push_back('{addr: instr_addr_o, due: cyc + 1});
    // model advance
    tgt = redirect_pc_i;
`ifndef MIRISCV_FETCH_MISALIGN_EN
    tgt[1:0] = 2'b00;
`endif
    pop_e = (fq.size() > 0) && fetch_ready_i && !redirect_i;
    mis_e = m_pend && (infl.size() == 0) && !redirect_i;
    if (pop_e) void'(fq.pop_front());
    if (instr_rvalid_i && infl.size() > 0) begin
      f = infl.pop_front();
      if (f.live && !redirect_i) fq.push_back('{pc: f.pc, instr: word(f.pc), mis: 1'b0});
    end
    if (mis_e) begin
      fq.push_back('{pc: m_mpc, instr: 32'h0, mis: 1'b1});
      m_pend = 1'b0;
    end
    if (req_e && instr_gnt_i) begin
      infl.push_back('{live: 1'b1, pc: m_addr});
      m_addr = m_addr + 32'd4;
    end
    if (redirect_i) begin
      fq.delete();
      foreach (infl[i]) infl[i].live = 1'b0;
      m_addr = tgt;
`ifdef MIRISCV_FETCH_MISALIGN_EN
      m_lock = (tgt[1:0] != 2'b00);
      m_pend = m_lock;
      m_mpc  = tgt;
`endif
    end
    cyc++;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    do begin step(); n++; end while (!fetch_valid_o && n < 40);
    checks++;
    if (!fetch_valid_o) begin
      failures++;
      $display("FAIL %s: fetch_valid_o still 0 after %0d cycles, required 1", nm, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    do_reset();

    // 1: a NOP memory with a one-cycle response and decode always ready
    nop_mem = 1'b1; p_gnt = 100; p_rv = 100; p_ready = 100; p_redir = 0;
    step(); chk("t1_req0", instr_req_o, 32'd1); chk("t1_addr0", instr_addr_o, 32'h0);
    step(); chk("t1_addr1", instr_addr_o, 32'h4);
    step(); chk("t1_v0", fetch_valid_o, 32'd1); chk("t1_pc0", fetch_pc_o, 32'h0);
            chk("t1_i0", fetch_instr_o, 32'h13);
    step(); chk("t1_v1", fetch_valid_o, 32'd1); chk("t1_pc1", fetch_pc_o, 32'h4);
            chk("t1_i1", fetch_instr_o, 32'h13); chk("t1_addr2", instr_addr_o, 32'h8);
    nop_mem = 1'b0;

    // 2: decode stalled; at most DEPTH words are fetched
    do_reset();
    p_ready = 0; g = 0;
    for (int i = 0; i < 6; i++) begin step(); if (instr_req_o && instr_gnt_i) g++; end
    chk("t2_grants", 32'(g), 32'd2);
    chk("t2_req_off", instr_req_o, 32'd0);
    p_ready = 100;
    step(); chk("t2_pc0", fetch_pc_o, 32'h0);
    step(); chk("t2_pc1", fetch_pc_o, 32'h4);
            chk("t2_req8", instr_req_o, 32'd1); chk("t2_addr8", instr_addr_o, 32'h8);

    // 3: redirect with two words in flight
    do_reset();
    p_rv = 0;
    step(); step(); step();
    chk("t3_req_off", instr_req_o, 32'd0);
    f_redir = 1'b1; f_pc = 32'h100; p_rv = 100;
    wait_valid("t3_wait");
    chk("t3_pc", fetch_pc_o, 32'h100);
    chk("t3_instr", fetch_instr_o, word(32'h100));

    // 4: redirect in the same cycle as a pop and a live response
    do_reset();
    p_ready = 0;
    step(); step();
    p_rv = 0; step();
    f_redir = 1'b1; f_pc = 32'h200; p_ready = 100; p_rv = 100;
    step(); chk("t4_valid_at_n", fetch_valid_o, 32'd1);
    step(); chk("t4_req", instr_req_o, 32'd1); chk("t4_addr", instr_addr_o, 32'h200);
            chk("t4_flushed", fetch_valid_o, 32'd0);
    wait_valid("t4_wait");
    chk("t4_pc", fetch_pc_o, 32'h200);

    // 5: misaligned redirect target
    do_reset();
    step(); step(); step();
    f_redir = 1'b1; f_pc = 32'h102;
    step();
`ifdef MIRISCV_FETCH_MISALIGN_EN
    wait_valid("t5_wait");
    chk("t5_mis", fetch_misalign_o, 32'd1);
    chk("t5_pc", fetch_pc_o, 32'h102);
    chk("t5_instr", fetch_instr_o, 32'h0);
    step(); step();
    chk("t5_req_off", instr_req_o, 32'd0);
`else
    step(); chk("t5_req", instr_req_o, 32'd1); chk("t5_addr", instr_addr_o, 32'h100);
`endif

    // 6: reset with the FIFO full, then a restart from RESET_PC
    do_reset();
    p_ready = 0;
    for (int i = 0; i < 5; i++) step();
    chk("t6_full", fetch_valid_o, 32'd1);
    do_reset();
    p_ready = 100;
    step(); chk("t6_req", instr_req_o, 32'd1); chk("t6_addr", instr_addr_o, RESET_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        p_gnt   = int'($urandom_range(20, 100));
        p_rv    = int'($urandom_range(20, 100));
        p_ready = int'($urandom_range(0, 100));
        p_redir = int'($urandom_range(0, 8));
      end
      if (i == 1600) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
